// File: rtl/ir_dram_loader.sv
// Diagnostic sequencer for the 512x15 IR dispatch RAM: stages a word from
// EBUS load functions, writes it with generated parity, and reads words back.
module ir_dram_loader #(
  parameter int unsigned DRAM_WIDTH     = 15,
  parameter int unsigned DRAM_ADDR_BITS = 9,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ebox_run,
  input  logic                      func_valid,
  input  logic [2:0]                func,
  input  logic [5:0]                data,
  output logic [DRAM_ADDR_BITS-1:0] dram_addr,
  output logic [DRAM_WIDTH-1:0]     dram_din,
  output logic                      dram_we,
  input  logic [DRAM_WIDTH-1:0]     dram_dout,
  output logic                      busy,
  output logic                      done,
  output logic [DRAM_WIDTH-1:0]     rd_word,
  output logic                      verify_err,
  output logic                      par_err,
  output logic                      reject
);

  localparam int unsigned CNT_W = 2;

  localparam logic [2:0] F_ADR_HI = 3'd0;
  localparam logic [2:0] F_ADR_LO = 3'd1;
  localparam logic [2:0] F_AB     = 3'd2;
  localparam logic [2:0] F_JHI    = 3'd3;
  localparam logic [2:0] F_JLO    = 3'd4;
  localparam logic [2:0] F_READ   = 3'd5;
  localparam logic [2:0] F_CLR    = 3'd6;
  localparam logic [2:0] F_MODE   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RDW   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DRAM_ADDR_BITS-1:0] adr_q, adr_d;
  logic [5:0]                ab_q, ab_d;
  logic [3:0]                jhi_q, jhi_d;
  logic [3:0]                jlo_q, jlo_d;
  logic                      autoinc_q, autoinc_d;
  logic                      verify_q, verify_d;
  logic                      chk_vfy_q, chk_vfy_d;
  logic [DRAM_WIDTH-1:0]     din_q, din_d;
  logic [DRAM_WIDTH-1:0]     rd_word_q, rd_word_d;
  logic                      we_q, we_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      verr_q, verr_d;
  logic                      perr_q, perr_d;
  logic                      rej_q, rej_d;
  logic                      accept;

  // Command decode, sequencing and sticky status
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    ab_d      = ab_q;
    jhi_d     = jhi_q;
    jlo_d     = jlo_q;
    autoinc_d = autoinc_q;
    verify_d  = verify_q;
    chk_vfy_d = chk_vfy_q;
    din_d     = din_q;
    rd_word_d = rd_word_q;
    verr_d    = verr_q;
    perr_d    = perr_q;
    rej_d     = rej_q;
    accept    = func_valid && (state_q == S_IDLE) && !ebox_run;

    if (func_valid && !accept) rej_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (func)
            F_ADR_HI: adr_d[DRAM_ADDR_BITS-1 -: 3] = data[2:0];
            F_ADR_LO: adr_d[5:0] = data;
            F_AB:     ab_d = data;
            F_JHI:    jhi_d = data[3:0];
            F_JLO: begin
              jlo_d   = data[3:0];
              state_d = S_WR;
            end
            F_READ: begin
              state_d   = S_RDW;
              cnt_d     = '0;
              chk_vfy_d = 1'b0;
            end
            F_CLR: begin
              verr_d = 1'b0;
              perr_d = 1'b0;
              rej_d  = 1'b0;
            end
            F_MODE: begin
              autoinc_d = data[0];
              verify_d  = data[1];
            end
            default: ;
          endcase
          if (func == F_AB || func == F_JHI || func == F_JLO)
            din_d = {ab_d, ~^{ab_d, jhi_d, jlo_d}, jhi_d, jlo_d};
        end
      end
      S_WR: begin
        if (verify_q) begin
          state_d   = S_RDW;
          cnt_d     = '0;
          chk_vfy_d = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_RDW: begin
        if (cnt_q == CNT_W'(READ_LATENCY - 1)) state_d = S_CHECK;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      S_CHECK: begin
        rd_word_d = dram_dout;
        if (!(^dram_dout)) perr_d = 1'b1;
        if (chk_vfy_q && (dram_dout != din_q)) verr_d = 1'b1;
        if (autoinc_q) adr_d = adr_q + DRAM_ADDR_BITS'(1);
        state_d = S_IDLE;
      end
      S_DONE: begin
        if (autoinc_q) adr_d = adr_q + DRAM_ADDR_BITS'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they line up with it
    we_d   = (state_d == S_WR);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_CHECK) || (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      adr_q     <= '0;
      ab_q      <= '0;
      jhi_q     <= '0;
      jlo_q     <= '0;
      autoinc_q <= 1'b0;
      verify_q  <= 1'b0;
      chk_vfy_q <= 1'b0;
      din_q     <= '0;
      rd_word_q <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      verr_q    <= 1'b0;
      perr_q    <= 1'b0;
      rej_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      ab_q      <= ab_d;
      jhi_q     <= jhi_d;
      jlo_q     <= jlo_d;
      autoinc_q <= autoinc_d;
      verify_q  <= verify_d;
      chk_vfy_q <= chk_vfy_d;
      din_q     <= din_d;
      rd_word_q <= rd_word_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      verr_q    <= verr_d;
      perr_q    <= perr_d;
      rej_q     <= rej_d;
    end
  end

  assign dram_addr  = adr_q;
  assign dram_din   = din_q;
  assign dram_we    = we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_word    = rd_word_q;
  assign verify_err = verr_q;
  assign par_err    = perr_q;
  assign reject     = rej_q;

endmodule

// File: doc/ir_dram_loader.md
Name: ir_dram_loader

Overview:
- Diagnostic-side sequencer that loads and reads back the 512x15 IR dispatch RAM (fields A[0:2], B[0:2], P, J[1:4], J[7:10]).
- The console/diagnostic path sends 6-bit EBUS-style load functions. The block stages a full DRAM word, generates its parity bit and issues a single write strobe.
- After each write it optionally reads the word back and compares it; it also services plain readback requests.
- It drives the DRAM write port that the IR block currently ties off. It is the only writer of that port.

Parameters:
- DRAM_WIDTH, 15, word width in the packing {A[0:2],B[0:2],P,J[1:4],J[7:10]}.
- DRAM_ADDR_BITS, 9, address width (512 words).
- READ_LATENCY, 1, clocks from address presented to dram_dout valid (range 1..3).

Ports:
- clk  in  1  single clock, same edge as CLK.IR.
- reset  in  1  synchronous, active-high.
- ebox_run  in  1  EBOX running; while 1 all commands are rejected.
- func_valid  in  1  one-cycle strobe; func/data are sampled when it is 1.
- func  in  3  load function code (see Behaviour).
- data  in  6  EBUS data bits [0:5], bit 0 = MSB.
- dram_addr  out  DRAM_ADDR_BITS  address to DRAM.
- dram_din  out  DRAM_WIDTH  write data to DRAM.
- dram_we  out  1  write strobe, exactly one cycle per write.
- dram_dout  in  DRAM_WIDTH  DRAM read data.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when a sequence completes.
- rd_word  out  DRAM_WIDTH  last word captured from dram_dout.
- verify_err  out  1  sticky; a post-write readback differed from the word written.
- par_err  out  1  sticky; a captured word has even parity.
- reject  out  1  sticky; a command arrived while busy or while ebox_run=1.

Behaviour:
- Reset: all outputs 0. Staged address, word fields, auto-increment and verify flags clear; state IDLE.
- Commands are sampled only in IDLE with ebox_run=0.
- A func_valid in any other condition is ignored and sets reject. That includes the cycle in which done is high (still CHECK).
- Function codes:
  - 0 ADR_HI: adr[0:2] <= data[3:5].
  - 1 ADR_LO: adr[3:8] <= data[0:5].
  - 2 AB: {A,B} <= data[0:5].
  - 3 JHI: J[1:4] <= data[2:5].
  - 4 JLO: J[7:10] <= data[2:5], then start WRITE sequence.
  - 5 READ: start READ sequence.
  - 6 CLR: clear verify_err, par_err and reject. Staging registers are not touched.
  - 7 MODE: autoinc <= data[5]; verify <= data[4].
- Codes 0-3, 6 and 7 take effect on the sampling edge and do not assert busy.
- Parity: P = ~^{A,B,J[1:4],J[7:10]}, so the 15-bit word has odd parity. dram_din = {A,B,P,J[1:4],J[7:10]}.
- dram_addr is always the staged address.
- State machine:
  - IDLE -> WR on JLO.
  - IDLE -> RDW on READ.
  - WR: dram_we=1 for this single cycle. Then go to RDW if verify=1, else DONE.
  - RDW: dram_we=0; counter runs READ_LATENCY cycles; then CHECK.
  - CHECK:
    - rd_word <= dram_dout.
    - par_err set if ^dram_dout == 0.
    - If reached via a write with verify=1, verify_err set if dram_dout != dram_din.
    - done=1; then IDLE.
  - DONE (write without verify): done=1; then IDLE.
- busy=1 in WR, RDW, CHECK and DONE.
- Latency, taking the func_valid edge as cycle 0:
  - write, no verify: we in cycle 1, done in cycle 2.
  - write + verify: we in cycle 1, done in cycle 2+READ_LATENCY.
  - read: done in cycle 1+READ_LATENCY.
- Auto-increment: if autoinc=1, address increments on the edge leaving CHECK/DONE, after capture. 511 wraps to 0.
- Address and data are held stable from WR through CHECK. Staging writes are blocked while busy, so the compare uses the written word.
- ebox_run rising mid-sequence does not abort; the sequence completes. Only new commands are rejected.
- reset mid-sequence returns to IDLE next edge with dram_we=0; no partial write is possible beyond the WR cycle already clocked.
- Sticky flags clear only on reset or CLR.

Test Plan:
- ADR_HI=0o5, ADR_LO=0o12, AB=0o25, JHI=0o13, JLO=0o06 with verify=0 -> dram_we one cycle in cycle 1, addr=9'o512, din=15'b010101_1_1011_0110 (P=1), done in cycle 2.
- MODE data=0o02 (verify on); repeat the write with the memory model returning the written word -> done in cycle 3 (L=1), rd_word=din, verify_err=0. Force dout bit 14 flipped -> verify_err=1 and par_err=1.
- MODE data=0o01 (autoinc on); address 9'o777, READ -> done, address becomes 0. A second READ reads word 0.
- func_valid during busy, and with ebox_run=1 -> no state change, no dram_we, reject=1. CLR -> reject=0.
- Assert reset in the RDW cycle -> next cycle all outputs 0, state IDLE. A following READ completes normally.
- Sweep READ_LATENCY=1,2,3 -> read done exactly in cycle 1+L, with rd_word captured from the matching dout.
